monitor_tx_responder: RTL

// Downstream stage of the monitor command state machine. It serves READ

---
 rtl/monitor_tx_responder.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/monitor_tx_responder.sv
// READ-response streamer: sends cmd, data_size, payload and an XOR checksum
// one byte at a time through uart_tx, honouring host flow control.
module monitor_tx_responder #(
  parameter int unsigned MAX_PAYLOAD_BYTES = 16,
  parameter int unsigned ADDR_W            = 4,
  parameter int unsigned BUSY_TIMEOUT      = 1000,
  parameter int unsigned DONE_TIMEOUT      = 10000
) (
  input  logic              clk50,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        cmd,
  input  logic [7:0]        data_size,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  input  logic              host_ready_n,
  output logic              tx_write,
  output logic [7:0]        tx_byte,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [7:0]        bytes_sent
);

  localparam int unsigned CNT_W = $clog2(DONE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(DONE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, WAIT_RDY, LAUNCH, WAIT_BUSY, WAIT_DONE, FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        idx_q, idx_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [7:0]        size_q, size_d;
  logic [7:0]        csum_q, csum_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] rd_addr_d;
  logic              tx_write_d, busy_d, done_d, error_d;
  logic [7:0]        tx_byte_d, bytes_sent_d;
  logic [7:0]        last_idx, next_idx, byte_sel;
  logic              go_finish;

  assign last_idx = size_q + 8'd2;
  assign next_idx = idx_q + 8'd1;

  // Source of the byte being loaded: header, checksum or payload memory.
  always_comb begin
    if (idx_q == 8'd0)          byte_sel = cmd_q;
    else if (idx_q == 8'd1)     byte_sel = size_q;
    else if (idx_q == last_idx) byte_sel = csum_q;
    else                        byte_sel = rd_data;
  end

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cmd_q      <= '0;
      size_q     <= '0;
      csum_q     <= '0;
      cnt_q      <= '0;
      rd_addr    <= '0;
      tx_write   <= 1'b0;
      tx_byte    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      bytes_sent <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cmd_q      <= cmd_d;
      size_q     <= size_d;
      csum_q     <= csum_d;
      cnt_q      <= cnt_d;
      rd_addr    <= rd_addr_d;
      tx_write   <= tx_write_d;
      tx_byte    <= tx_byte_d;
      busy       <= busy_d;
      done       <= done_d;
      error      <= error_d;
      bytes_sent <= bytes_sent_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cmd_d        = cmd_q;
    size_d       = size_q;
    csum_d       = csum_q;
    rd_addr_d    = rd_addr;
    tx_write_d   = tx_write;
    tx_byte_d    = tx_byte;
    busy_d       = busy;
    done_d       = 1'b0;
    error_d      = error;
    bytes_sent_d = bytes_sent;
    go_finish    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          cmd_d        = cmd;
          size_d       = data_size;
          error_d      = 1'b0;
          bytes_sent_d = '0;
          csum_d       = '0;
          idx_d        = '0;
          busy_d       = 1'b1;
          if (32'(data_size) > MAX_PAYLOAD_BYTES) begin
            error_d   = 1'b1;
            go_finish = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        tx_byte_d = byte_sel;
        if (idx_q != last_idx) csum_d = csum_q ^ byte_sel;
        state_d = WAIT_RDY;
      end
      WAIT_RDY: begin
        if (!host_ready_n) begin
          tx_write_d = 1'b1;
          state_d    = LAUNCH;
        end
      end
      LAUNCH: state_d = WAIT_BUSY;
      // tx_write stays high until uart_tx acknowledges on its slower clock.
      WAIT_BUSY: begin
        if (tx_busy) begin
          tx_write_d = 1'b0;
          state_d    = WAIT_DONE;
        end else if (cnt_q == BUSY_LAST) begin
          error_d   = 1'b1;
          go_finish = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          bytes_sent_d = bytes_sent + 8'd1;
          if (idx_q == last_idx) begin
            go_finish = 1'b1;
          end else begin
            idx_d = next_idx;
            if (next_idx >= 8'd2 && next_idx <= size_q + 8'd1) begin
              rd_addr_d = ADDR_W'(idx_q - 8'd1);
              state_d   = FETCH;
            end else begin
              state_d = LOAD;
            end
          end
        end else if (cnt_q == DONE_LAST) begin
          error_d   = 1'b1;
          go_finish = 1'b1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (go_finish) begin
      state_d    = FINISH;
      busy_d     = 1'b0;
      done_d     = 1'b1;
      tx_write_d = 1'b0;
    end

    // Per-state cycle counter, restarted on every state change.
    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    else                     cnt_d = cnt_q;
  end

endmodule
